// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes, functs,
// ALU class codes, datapath mux selects and exception causes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_EXC = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_BR  = 3'b001;
  localparam logic [2:0] ALU_R   = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MDR = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_OP      = 2'b01;
  localparam logic [1:0] EXC_FUNCT   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  function automatic logic funct_legal(input logic [5:0] fn);
    return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                      FN_JR, FN_JALR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class,
// illegal-instruction cause and ALU class code.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int BNE_EN = 1
) (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic       o_is_rtype,
  output logic       o_is_jr,
  output logic       o_is_jalr,
  output logic       o_is_shift,
  output logic       o_is_itype,
  output logic       o_is_branch,
  output logic       o_is_jump,
  output logic       o_is_jal,
  output logic       o_is_mem,
  output logic       o_is_lw,
  output logic [1:0] o_ill_cause,
  output logic [2:0] o_alu_cls
);

  always_comb begin
    o_is_rtype  = (i_opcode == OP_RTYPE);
    o_is_jr     = o_is_rtype && (i_funct == FN_JR);
    o_is_jalr   = o_is_rtype && (i_funct == FN_JALR);
    o_is_shift  = o_is_rtype && (i_funct inside {FN_SLL, FN_SRL, FN_SRA});
    o_is_itype  = i_opcode inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                   OP_ANDI, OP_ORI, OP_LUI};
    // bne falls through to illegal when the option is off
    o_is_branch = (i_opcode == OP_BEQ) || ((BNE_EN != 0) && (i_opcode == OP_BNE));
    o_is_jal    = (i_opcode == OP_JAL);
    o_is_jump   = (i_opcode == OP_J) || o_is_jal;
    o_is_lw     = (i_opcode == OP_LW);
    o_is_mem    = o_is_lw || (i_opcode == OP_SW);

    o_ill_cause = EXC_NONE;
    if (o_is_rtype && !funct_legal(i_funct))
      o_ill_cause = EXC_FUNCT;
    else if (!(o_is_rtype || o_is_itype || o_is_branch || o_is_jump || o_is_mem))
      o_ill_cause = EXC_OP;

    o_alu_cls = ALU_ADD;
    if (o_is_rtype && !o_is_jr && !o_is_jalr)
      o_alu_cls = ALU_R;
    else if (o_is_branch)
      o_alu_cls = ALU_BR;
    else if (i_opcode == OP_ANDI)
      o_alu_cls = ALU_AND;
    else if (i_opcode == OP_ORI)
      o_alu_cls = ALU_OR;
    else if ((i_opcode == OP_SLTI) || (i_opcode == OP_SLTIU))
      o_alu_cls = ALU_SLT;
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multi-cycle CPU control FSM with memory wait states and a timeout watchdog.
// Define CTRL_EXC_EN to add the S_EXC exception state and exc_take/exc_cause ports.
module multicycle_ctrl_v2
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int BNE_EN      = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic               i_mem_ready,
  output logic               o_pc_write,
  output logic               o_pc_write_cond,
  output logic               o_branch_ne,
  output logic               o_iord,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic [1:0]         o_mem_to_reg,
  output logic [1:0]         o_reg_dst,
  output logic               o_reg_write,
  output logic               o_ext_op,
  output logic               o_lui_op,
  output logic [1:0]         o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_pc_source,
  output logic               o_mem_err,
`ifdef CTRL_EXC_EN
  output logic               o_exc_take,
  output logic [1:0]         o_exc_cause,
`endif
  output logic [2:0]         o_state
);

  state_t       r_state, w_next;
  logic [7:0]   r_wait;
  logic         r_mem_err;
  logic         w_waiting, w_timeout;

  logic w_is_rtype, w_is_jr, w_is_jalr, w_is_shift, w_is_itype, w_is_branch;
  logic w_is_jump, w_is_jal, w_is_mem, w_is_lw;
  logic [1:0] w_ill_cause;
  logic [2:0] w_dec_cls, w_cls;

  logic w_pc_write, w_pc_write_cond, w_branch_ne, w_iord, w_mem_read, w_mem_write;
  logic w_ir_write, w_reg_write, w_ext_op, w_lui_op;
  logic [1:0] w_mem_to_reg, w_reg_dst, w_alu_src_a, w_alu_src_b, w_pc_source;
  logic [ALUOP_W-1:0] w_alu_op;
`ifdef CTRL_EXC_EN
  logic       w_exc_take;
  logic [1:0] w_cause, r_cause;
`endif

  ctrl_decode #(.BNE_EN(BNE_EN)) u_dec (
    .i_opcode    (i_opcode),
    .i_funct     (i_funct),
    .o_is_rtype  (w_is_rtype),
    .o_is_jr     (w_is_jr),
    .o_is_jalr   (w_is_jalr),
    .o_is_shift  (w_is_shift),
    .o_is_itype  (w_is_itype),
    .o_is_branch (w_is_branch),
    .o_is_jump   (w_is_jump),
    .o_is_jal    (w_is_jal),
    .o_is_mem    (w_is_mem),
    .o_is_lw     (w_is_lw),
    .o_ill_cause (w_ill_cause),
    .o_alu_cls   (w_dec_cls)
  );

  // Wait cycles are IF/MEM cycles that do not see mem_ready
  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !i_mem_ready;
  assign w_timeout = w_waiting && (r_wait == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_IF;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_waiting && (r_wait != 8'(MEM_TIMEOUT)))
        r_wait <= r_wait + 8'd1;
      if (w_timeout)
        r_mem_err <= 1'b1;
    end
  end

`ifdef CTRL_EXC_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset)
      r_cause <= EXC_NONE;
    else if (w_next == S_EXC)
      r_cause <= w_cause;
  end
`endif

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_ext_op        = 1'b0;
    w_lui_op        = 1'b0;
    w_mem_to_reg    = MTR_ALU;
    w_reg_dst       = DST_RT;
    w_alu_src_a     = SRCA_PC;
    w_alu_src_b     = SRCB_RT;
    w_pc_source     = PCS_ALU;
    w_cls           = ALU_ADD;
`ifdef CTRL_EXC_EN
    w_exc_take      = 1'b0;
    w_cause         = EXC_NONE;
`endif
    case (r_state)
      S_IF: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_4;
        if (i_mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_ID;
        end
`ifdef CTRL_EXC_EN
        else if (w_timeout) begin
          w_mem_read = 1'b0;
          w_cause    = EXC_TIMEOUT;
          w_next     = S_EXC;
        end
`endif
      end
      S_ID: begin
        w_alu_src_b = SRCB_IMM2;
        w_ext_op    = 1'b1;
        w_next      = S_EX;
      end
      S_EX: begin
        w_cls  = w_dec_cls;
        w_next = S_IF;
        if (w_ill_cause != EXC_NONE) begin
`ifdef CTRL_EXC_EN
          w_cause = w_ill_cause;
          w_next  = S_EXC;
`endif
        end else if (w_is_jump) begin
          w_pc_write  = 1'b1;
          w_pc_source = PCS_JUMP;
          if (w_is_jal) begin
            w_reg_write  = 1'b1;
            w_reg_dst    = DST_RA;
            w_mem_to_reg = MTR_PC;
          end
        end else if (w_is_branch) begin
          w_alu_src_a     = SRCA_RS;
          w_alu_src_b     = SRCB_RT;
          w_pc_write_cond = 1'b1;
          w_pc_source     = PCS_ALUOUT;
          w_branch_ne     = (i_opcode == OP_BNE);
        end else if (w_is_jr || w_is_jalr) begin
          w_pc_write  = 1'b1;
          w_pc_source = PCS_RS;
          if (w_is_jalr) begin
            w_reg_write  = 1'b1;
            w_reg_dst    = DST_RD;
            w_mem_to_reg = MTR_PC;
          end
        end else if (w_is_rtype) begin
          w_alu_src_a = w_is_shift ? SRCA_SHAMT : SRCA_RS;
          w_alu_src_b = SRCB_RT;
          w_next      = S_WB;
        end else if (w_is_mem) begin
          w_alu_src_a = SRCA_RS;
          w_alu_src_b = SRCB_IMM;
          w_ext_op    = 1'b1;
          w_next      = S_MEM;
        end else if (w_is_itype) begin
          w_alu_src_a = SRCA_RS;
          w_alu_src_b = SRCB_IMM;
          w_ext_op    = !((i_opcode == OP_ANDI) || (i_opcode == OP_ORI));
          w_lui_op    = (i_opcode == OP_LUI);
          w_next      = S_WB;
        end
      end
      S_MEM: begin
        w_cls  = w_dec_cls;
        w_iord = 1'b1;
        if (w_is_lw) w_mem_read  = 1'b1;
        else         w_mem_write = 1'b1;
        if (i_mem_ready)
          w_next = w_is_lw ? S_WB : S_IF;
`ifdef CTRL_EXC_EN
        else if (w_timeout) begin
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_cause     = EXC_TIMEOUT;
          w_next      = S_EXC;
        end
`endif
      end
      S_WB: begin
        w_cls       = w_dec_cls;
        w_reg_write = 1'b1;
        if (w_is_rtype)
          w_reg_dst = DST_RD;
        else if (w_is_lw)
          w_mem_to_reg = MTR_MDR;
        w_next = S_IF;
      end
`ifdef CTRL_EXC_EN
      S_EXC: begin
        w_exc_take = 1'b1;
        w_pc_write = 1'b1;
        w_next     = S_IF;
      end
`endif
      default: w_next = S_IF;
    endcase
  end

  // Bits between the class code and the MSB stay zero
  always_comb begin
    w_alu_op              = '0;
    w_alu_op[ALUOP_W-1]   = i_opcode[0];
    w_alu_op[2:0]         = w_cls;
  end

  assign o_pc_write      = w_pc_write      & i_reset;
  assign o_pc_write_cond = w_pc_write_cond & i_reset;
  assign o_mem_read      = w_mem_read      & i_reset;
  assign o_mem_write     = w_mem_write     & i_reset;
  assign o_ir_write      = w_ir_write      & i_reset;
  assign o_reg_write     = w_reg_write     & i_reset;
  assign o_branch_ne     = w_branch_ne;
  assign o_iord          = w_iord;
  assign o_mem_to_reg    = w_mem_to_reg;
  assign o_reg_dst       = w_reg_dst;
  assign o_ext_op        = w_ext_op;
  assign o_lui_op        = w_lui_op;
  assign o_alu_src_a     = w_alu_src_a;
  assign o_alu_src_b     = w_alu_src_b;
  assign o_alu_op        = w_alu_op;
  assign o_pc_source     = w_pc_source;
  assign o_mem_err       = r_mem_err;
  assign o_state         = r_state;
`ifdef CTRL_EXC_EN
  assign o_exc_take      = w_exc_take;
  assign o_exc_cause     = w_exc_take ? r_cause : EXC_NONE;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: random instruction streams against a per-phase
// trace model, plus directed watchdog and mid-access reset checks.
module tb_multicycle_ctrl_v2;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mr;
  logic [5:0] op, fn;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic a_pcw, a_pwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_rw, a_ext, a_lui, a_err;
  logic [1:0] a_mtr, a_dst, a_sa, a_sb, a_pcs;
  logic [3:0] a_aop;
  logic [2:0] a_st;
  logic b_pcw, b_pwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_rw, b_ext, b_lui, b_err;
  logic [1:0] b_mtr, b_dst, b_sa, b_sb, b_pcs;
  logic [3:0] b_aop;
  logic [2:0] b_st;
`ifdef CTRL_EXC_EN
  logic       a_xt, b_xt;
  logic [1:0] a_xc, b_xc;
`endif

  multicycle_ctrl_v2 #(.ALUOP_W(4), .MEM_TIMEOUT(15), .BNE_EN(1)) u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_opcode(op), .i_funct(fn), .i_mem_ready(mr),
    .o_pc_write(a_pcw), .o_pc_write_cond(a_pwc), .o_branch_ne(a_bne), .o_iord(a_iord),
    .o_mem_read(a_mrd), .o_mem_write(a_mwr), .o_ir_write(a_irw), .o_mem_to_reg(a_mtr),
    .o_reg_dst(a_dst), .o_reg_write(a_rw), .o_ext_op(a_ext), .o_lui_op(a_lui),
    .o_alu_src_a(a_sa), .o_alu_src_b(a_sb), .o_alu_op(a_aop), .o_pc_source(a_pcs),
    .o_mem_err(a_err),
`ifdef CTRL_EXC_EN
    .o_exc_take(a_xt), .o_exc_cause(a_xc),
`endif
    .o_state(a_st));

  multicycle_ctrl_v2 #(.ALUOP_W(4), .MEM_TIMEOUT(15), .BNE_EN(0)) u_dut_nb (
    .i_clk(clk), .i_reset(rst_n), .i_opcode(op), .i_funct(fn), .i_mem_ready(mr),
    .o_pc_write(b_pcw), .o_pc_write_cond(b_pwc), .o_branch_ne(b_bne), .o_iord(b_iord),
    .o_mem_read(b_mrd), .o_mem_write(b_mwr), .o_ir_write(b_irw), .o_mem_to_reg(b_mtr),
    .o_reg_dst(b_dst), .o_reg_write(b_rw), .o_ext_op(b_ext), .o_lui_op(b_lui),
    .o_alu_src_a(b_sa), .o_alu_src_b(b_sb), .o_alu_op(b_aop), .o_pc_source(b_pcs),
    .o_mem_err(b_err),
`ifdef CTRL_EXC_EN
    .o_exc_take(b_xt), .o_exc_cause(b_xc),
`endif
    .o_state(b_st));

  logic [27:0] a_vec, b_vec;
  assign a_vec = {a_st, a_pcw, a_pwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_mtr, a_dst,
                  a_rw, a_ext, a_lui, a_sa, a_sb, a_aop, a_pcs, a_err};
  assign b_vec = {b_st, b_pcw, b_pwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_mtr, b_dst,
                  b_rw, b_ext, b_lui, b_sa, b_sb, b_aop, b_pcs, b_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit rlegal(input logic [5:0] f);
    return f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                     [6'h20:6'h27], 6'h2a, 6'h2b};
  endfunction

  function automatic bit itype(input logic [5:0] o);
    return o inside {[6'h08:6'h0d], 6'h0f};
  endfunction

  // Expected output vector for one cycle of an instruction in a given phase
  function automatic logic [27:0] expv(input state_t ph, input logic [5:0] o,
                                       input logic [5:0] f, input logic r, input bit bne_en);
    logic pcw = 0, pwc = 0, bne = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic rw = 0, ext = 0, lui = 0;
    logic [1:0] mtr = 0, dst = 0, sa = 0, sb = 0, pcs = 0;
    logic [2:0] cls = 0;
    bit rt = (o == 6'h00);
    bit br = (o == 6'h04) || (o == 6'h05 && bne_en);
    if (ph != S_IF && ph != S_ID) begin
      if (rt && f != 6'h08 && f != 6'h09) cls = 3'b010;
      else if (br)                        cls = 3'b001;
      else if (o == 6'h0c)                cls = 3'b100;
      else if (o == 6'h0d)                cls = 3'b110;
      else if (o == 6'h0a || o == 6'h0b)  cls = 3'b101;
    end
    case (ph)
      S_IF: begin mrd = 1; sb = 2'b01; if (r) begin irw = 1; pcw = 1; end end
      S_ID: begin sb = 2'b11; ext = 1; end
      S_EX: begin
        if (o == 6'h02 || o == 6'h03) begin
          pcw = 1; pcs = 2'b10;
          if (o == 6'h03) begin rw = 1; dst = 2'b10; mtr = 2'b10; end
        end else if (br) begin
          sa = 2'b01; sb = 2'b00; pwc = 1; pcs = 2'b01; bne = (o == 6'h05);
        end else if (rt && rlegal(f)) begin
          if (f == 6'h08 || f == 6'h09) begin
            pcw = 1; pcs = 2'b11;
            if (f == 6'h09) begin rw = 1; dst = 2'b01; mtr = 2'b10; end
          end else begin
            sa = (f == 6'h00 || f == 6'h02 || f == 6'h03) ? 2'b10 : 2'b01;
          end
        end else if (o == 6'h23 || o == 6'h2b) begin
          sa = 2'b01; sb = 2'b10; ext = 1;
        end else if (itype(o)) begin
          sa = 2'b01; sb = 2'b10; ext = !(o == 6'h0c || o == 6'h0d); lui = (o == 6'h0f);
        end
      end
      S_MEM: begin iord = 1; if (o == 6'h2b) mwr = 1; else mrd = 1; end
      S_WB: begin rw = 1; if (rt) dst = 2'b01; else if (o == 6'h23) mtr = 2'b01; end
      default: ;
    endcase
    return {3'(ph), pcw, pwc, bne, iord, mrd, mwr, irw, mtr, dst, rw, ext, lui,
            sa, sb, o[0], cls, pcs, 1'b0};
  endfunction

  // Build the phase trace for one instruction, then drive and check each cycle
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int wif, input int wmem);
    state_t ph[$];
    logic   rq[$];
    repeat (wif) begin ph.push_back(S_IF); rq.push_back(1'b0); end
    ph.push_back(S_IF); rq.push_back(1'b1);
    ph.push_back(S_ID); rq.push_back(1'($urandom));
    ph.push_back(S_EX); rq.push_back(1'($urandom));
    if (o == 6'h23 || o == 6'h2b) begin
      repeat (wmem) begin ph.push_back(S_MEM); rq.push_back(1'b0); end
      ph.push_back(S_MEM); rq.push_back(1'b1);
      if (o == 6'h23) begin ph.push_back(S_WB); rq.push_back(1'($urandom)); end
    end else if (itype(o) || (o == 6'h00 && rlegal(f) && f != 6'h08 && f != 6'h09)) begin
      ph.push_back(S_WB); rq.push_back(1'($urandom));
    end
    for (int i = 0; i < ph.size(); i++) begin
      op = o; fn = f; mr = rq[i];
      @(negedge clk);
      chk($sformatf("op%02h_fn%02h_c%0d", o, f, i), 32'(a_vec), 32'(expv(ph[i], o, f, rq[i], 1)));
`ifndef CTRL_EXC_EN
      chk($sformatf("nb_op%02h_fn%02h_c%0d", o, f, i), 32'(b_vec), 32'(expv(ph[i], o, f, rq[i], 0)));
`endif
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] t_op [23] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03,
                            6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f,
                            6'h23, 6'h2b, 6'h00, 6'h3f, 6'h0e};
  logic [5:0] t_fn [23] = '{6'h20, 6'h22, 6'h00, 6'h03, 6'h2a, 6'h08, 6'h09, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h00, 6'h00, 6'h01, 6'h00, 6'h00};

  initial begin
    int k, last, nto;
    logic [5:0] f;
    rst_n = 1'b0; mr = 1'b0; op = 6'h2b; fn = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(a_mrd), 32'd0);
    chk("rst_state", 32'(a_st), 32'(S_IF));
    chk("rst_mem_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0);   // add
    run_instr(6'h23, 6'h00, 0, 3);   // lw, three MEM wait states
    run_instr(6'h05, 6'h11, 0, 0);   // bne
    run_instr(6'h00, 6'h09, 0, 0);   // jalr
    run_instr(6'h0f, 6'h3c, 2, 0);   // lui with IF waits

`ifdef CTRL_EXC_EN
    last = 19;
`else
    last = 22;
`endif
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, last);
      f = (t_op[k] == 6'h00) ? t_fn[k] : 6'($urandom);
      run_instr(t_op[k], f, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Watchdog: mem_ready stuck low in IF
    mr = 1'b0; op = 6'h2b; fn = 6'h00;
`ifdef CTRL_EXC_EN
    nto = 16;
`else
    nto = 20;
`endif
    for (int c = 1; c <= nto; c++) begin
      @(posedge clk); #1;
      if (c == 14) chk("wd_err_before", 32'(a_err), 32'd0);
      if (c == 15) chk("wd_err_fire", 32'(a_err), 32'd1);
`ifdef CTRL_EXC_EN
      if (c == 15) chk("wd_exc_take", 32'({a_st, a_xt, a_xc}), 32'({S_EXC, 1'b1, 2'b11}));
      if (c == 16) chk("wd_exc_pulse", 32'(a_xt), 32'd0);
`endif
    end
    chk("wd_state_if", 32'(a_st), 32'(S_IF));
    chk("wd_err_hold", 32'(a_err), 32'd1);

    // sw then reset in the middle of its MEM access
    mr = 1'b1;
    @(posedge clk); #1;
    chk("sw_id", 32'(a_st), 32'(S_ID));
    mr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_mem_state", 32'(a_st), 32'(S_MEM));
    chk("sw_mem_write", 32'(a_mwr), 32'd1);
    chk("sw_err_sticky", 32'(a_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_write", 32'(a_mwr), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_state", 32'(a_st), 32'(S_IF));
    chk("rst_mid_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;
    run_instr(6'h2b, 6'h00, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
